unidade_io: RTL and testbench
=============================

UNIDADE_IO -- requirements
Module: unidade_io

Interface
REQ-001 Parameter DEB_CYCLES, default 4, is the number of consecutive stable synchronized samples needed to accept a button level change; legal range is 1..2^20-1.
REQ-002 Port clk, input, 1 bit: single processor clock, rising-edge active.
REQ-003 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 Port IOE, input, 1 bit: I/O enable from the control unit.
REQ-005 Port IOsel, input, 1 bit: I/O direction from the control unit (1 = IN, 0 = OUT).
REQ-006 Port stall, input, 1 bit: IN-stall request from the control unit; it is qualified with IOE.
REQ-007 Port switches, input, 16 bits: raw board switch value.
REQ-008 Port btn_ok, input, 1 bit: raw, asynchronous, bouncing confirm button (1 = pressed).
REQ-009 Port rs_data, input, 32 bits: register-file RS value used by OUT.
REQ-010 Port in_data, output, 32 bits: IN result sent to the write-back mux.
REQ-011 Port hold, output, 1 bit: freezes the PC and blocks register write while 1.
REQ-012 Port out_reg, output, 32 bits: value latched by the last OUT, driving the display.
REQ-013 Port out_valid, output, 1 bit: one-cycle pulse on each OUT.

Function
REQ-014 btn_ok shall pass through a 2-flop synchronizer before any other use.
- Debouncer: counter up to 20 bits.
- Counter resets to 0 when the synchronized level equals btn_db.
- Otherwise it increments; btn_db toggles when the count reaches DEB_CYCLES, and the counter then clears.
REQ-015 IN request is defined as in_req = IOE & IOsel & stall.
REQ-016 FSM states and transitions:
- IDLE -> WAIT_PRESS when in_req=1 and btn_db=0.
- IDLE -> WAIT_REL when in_req=1 and btn_db=1.
- WAIT_REL -> WAIT_PRESS when btn_db=0.
- WAIT_PRESS -> DONE when btn_db=1; on the same edge in_data is loaded with {16'b0, switches}.
- DONE -> IDLE unconditionally.
REQ-017 hold is combinational: hold = in_req & (state != DONE) & ~rst.
- hold is therefore 1 in the same cycle IN is first decoded.
- hold is 0 for exactly one cycle in DONE, so write-back and PC advance occur on that edge.
REQ-018 in_data shall change only on the WAIT_PRESS -> DONE edge and otherwise hold its value.
REQ-019 If in_req drops while in WAIT_REL or WAIT_PRESS (e.g. after a pipeline flush), the FSM shall return to IDLE on the next edge without loading in_data.
REQ-020 OUT occurs when IOE=1 and IOsel=0 on a rising edge:
- out_reg <= rs_data.
- out_valid = 1 for the following cycle only.
- hold stays 0; an OUT never stalls.
REQ-021 Back-to-back OUTs shall pulse out_valid on every cycle and update out_reg every cycle.
REQ-022 IOE=0 shall leave every state, register and output unchanged, except that the debouncer keeps running.
REQ-023 Latency:
- IN: minimum total stall is 2 synchronizer cycles + DEB_CYCLES + 1 DONE cycle from a clean press.
- OUT: visible on out_reg 1 cycle after the edge.

Reset
REQ-024 While rst=1, regardless of clock:
- state = IDLE, btn_db = 0, debounce counter = 0, synchronizer flops = 0.
- in_data = 0, out_reg = 0, out_valid = 0, hold = 0.
REQ-025 If rst is asserted mid-IN, hold shall deassert immediately with no in_data update. After release, a still-present in_req restarts from IDLE.

Verification
REQ-026 OUT: IOE=1, IOsel=0, rs_data=32'h0000_00A5 for one cycle -> out_reg=32'h0000_00A5, out_valid=1 for exactly one cycle, hold=0 throughout.
REQ-027 IN with clean press: DEB_CYCLES=4, in_req held, switches=16'h1234, btn_ok rises at cycle 3 -> hold=1 from cycle 0, DONE at cycle 10, in_data=32'h0000_1234, hold=0 only in cycle 10, state IDLE at cycle 11.
REQ-028 Bounce: btn_ok toggles every 2 cycles for 12 cycles, then stays high -> no capture during the bounce, and a single capture occurs DEB_CYCLES+2 cycles after it stabilizes.
REQ-029 Held button: btn_db=1 when in_req arrives -> FSM enters WAIT_REL and does not capture until a debounced release followed by a new debounced press.
REQ-030 Reset in WAIT_PRESS: rst pulsed while hold=1 -> hold=0 and in_data=0 immediately. After release with in_req still high, hold=1 again and the FSM is in WAIT_PRESS next cycle.
REQ-031 Flush: in_req drops while in WAIT_PRESS -> IDLE next cycle, in_data unchanged, hold=0.

Source files
------------

// File: rtl/unidade_io.sv
// Processor I/O unit: blocking IN from board switches gated by a debounced
// confirm button, and a registered OUT port that drives the display.
module unidade_io #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IOE,
  input  logic        IOsel,
  input  logic        stall,
  input  logic [15:0] switches,
  input  logic        btn_ok,
  input  logic [31:0] rs_data,
  output logic [31:0] in_data,
  output logic        hold,
  output logic [31:0] out_reg,
  output logic        out_valid
);

  localparam logic [19:0] DEB_LAST = 20'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_REL,
    WAIT_PRESS,
    DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_sync0;
  logic        r_sync1;
  logic        r_btn_db;
  logic [19:0] r_deb_cnt;
  logic [31:0] r_in_data;
  logic [31:0] r_out_reg;
  logic        r_out_valid;
  logic        w_in_req;
  logic        w_out_req;
  logic        w_capture;

  assign w_in_req  = IOE & IOsel & stall;
  assign w_out_req = IOE & ~IOsel;

  // Debouncer runs regardless of IOE; a level is accepted after DEB_CYCLES
  // consecutive synchronized samples that differ from the accepted level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync0   <= 1'b0;
      r_sync1   <= 1'b0;
      r_btn_db  <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      r_sync0 <= btn_ok;
      r_sync1 <= r_sync0;
      if (r_sync1 == r_btn_db) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_LAST) begin
        r_btn_db  <= ~r_btn_db;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + 20'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Wait states are frozen while IOE=0; with IOE=1 a dropped request aborts.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_in_req) begin
          w_next = r_btn_db ? WAIT_REL : WAIT_PRESS;
        end
      end
      WAIT_REL: begin
        if (IOE) begin
          if (!w_in_req) begin
            w_next = IDLE;
          end else if (!r_btn_db) begin
            w_next = WAIT_PRESS;
          end
        end
      end
      WAIT_PRESS: begin
        if (IOE) begin
          if (!w_in_req) begin
            w_next = IDLE;
          end else if (r_btn_db) begin
            w_next    = DONE;
            w_capture = 1'b1;
          end
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_data   <= '0;
      r_out_reg   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_capture) begin
        r_in_data <= {16'h0000, switches};
      end
      if (w_out_req) begin
        r_out_reg <= rs_data;
      end
      r_out_valid <= w_out_req;
    end
  end

  assign hold      = w_in_req & (r_state != DONE) & ~rst;
  assign in_data   = r_in_data;
  assign out_reg   = r_out_reg;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_unidade_io.sv
// Directed bench for unidade_io: expected values are queued when stimulus is
// applied and popped when the corresponding output is sampled.
module tb_unidade_io;

  logic        clk = 1'b0;
  logic        rst;
  logic        IOE;
  logic        IOsel;
  logic        stall;
  logic [15:0] switches;
  logic        btn_ok;
  logic [31:0] rs_data;
  logic [31:0] in_data;
  logic        hold;
  logic [31:0] out_reg;
  logic        out_valid;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_pass   = 0;
  int unsigned n_checks = 0;

  always #5 clk = ~clk;

  unidade_io #(.DEB_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .IOE      (IOE),
    .IOsel    (IOsel),
    .stall    (stall),
    .switches (switches),
    .btn_ok   (btn_ok),
    .rs_data  (rs_data),
    .in_data  (in_data),
    .hold     (hold),
    .out_reg  (out_reg),
    .out_valid(out_valid)
  );

  task automatic exp_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_obs(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      e.tag = "scoreboard_empty";
      e.val = 32'hBAD0_BAD0;
    end else begin
      e = sb.pop_front();
    end
    assert (obs === e.val) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] v;
    rst      = 1'b1;
    IOE      = 1'b0;
    IOsel    = 1'b0;
    stall    = 1'b0;
    btn_ok   = 1'b0;
    switches = 16'h0000;
    rs_data  = 32'h0;

    // Reset state
    #12;
    exp_push("rst_in_data", 32'h0);   check_obs(in_data);
    exp_push("rst_out_reg", 32'h0);   check_obs(out_reg);
    exp_push("rst_out_valid", 32'h0); check_obs(32'(out_valid));
    exp_push("rst_hold", 32'h0);      check_obs(32'(hold));
    step();
    rst = 1'b0;
    step();

    // Single OUT
    IOE = 1'b1; IOsel = 1'b0; rs_data = 32'h0000_00A5;
    exp_push("out_hold_c0", 32'h0);
    exp_push("out_reg_c1", 32'h0000_00A5);
    exp_push("out_valid_c1", 32'h1);
    exp_push("out_hold_c1", 32'h0);
    #1 check_obs(32'(hold));
    step();
    IOE = 1'b0; rs_data = 32'hFFFF_FFFF;
    #1;
    check_obs(out_reg);
    check_obs(32'(out_valid));
    check_obs(32'(hold));
    step();
    exp_push("out_valid_c2", 32'h0);
    exp_push("out_reg_c2", 32'h0000_00A5);
    #1;
    check_obs(32'(out_valid));
    check_obs(out_reg);

    // Back-to-back OUTs
    step();
    IOE = 1'b1; IOsel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v = 32'h1000_0000 + 32'(i) * 32'h0101_0011;
      rs_data = v;
      exp_push("b2b_out_reg", v);
      exp_push("b2b_out_valid", 32'h1);
      step();
      #1;
      check_obs(out_reg);
      check_obs(32'(out_valid));
    end
    IOE = 1'b0;
    step();
    exp_push("b2b_valid_end", 32'h0);
    exp_push("b2b_reg_end", 32'h1303_0033);
    #1;
    check_obs(32'(out_valid));
    check_obs(out_reg);

    // IN with clean press: button rises in cycle 3, DONE in cycle 10
    step();
    IOE = 1'b1; IOsel = 1'b1; stall = 1'b1; switches = 16'h1234;
    for (int c = 0; c <= 11; c++) begin
      if (c > 0) step();
      if (c == 3) btn_ok = 1'b1;
      exp_push($sformatf("in_hold_c%0d", c), (c == 10) ? 32'h0 : 32'h1);
      #1 check_obs(32'(hold));
      if (c == 9) begin
        exp_push("in_data_c9", 32'h0);
        check_obs(in_data);
      end
      if (c == 10) begin
        exp_push("in_data_c10", 32'h0000_1234);
        check_obs(in_data);
      end
    end
    stall = 1'b0;
    btn_ok = 1'b0;
    repeat (8) step();

    // Bounce: no capture while bouncing, one capture after stabilising
    IOE = 1'b1; IOsel = 1'b1; stall = 1'b1; switches = 16'hBEEF;
    for (int k = 0; k < 12; k++) begin
      btn_ok = ((k / 2) % 2 == 0) ? 1'b1 : 1'b0;
      exp_push("bounce_hold", 32'h1);
      #1 check_obs(32'(hold));
      step();
    end
    btn_ok = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) step();
      exp_push($sformatf("stable_hold_c%0d", c), (c == 7) ? 32'h0 : 32'h1);
      exp_push($sformatf("stable_in_data_c%0d", c), (c == 7) ? 32'h0000_BEEF : 32'h0000_1234);
      #1;
      check_obs(32'(hold));
      check_obs(in_data);
    end
    stall = 1'b0;
    step();

    // Held button: WAIT_REL until release, then a fresh press
    stall = 1'b1; switches = 16'h5A5A;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) step();
      exp_push("held_hold", 32'h1);
      #1 check_obs(32'(hold));
    end
    exp_push("held_in_data", 32'h0000_BEEF);
    check_obs(in_data);
    step();
    btn_ok = 1'b0;
    for (int c = 0; c <= 15; c++) begin
      if (c > 0) step();
      if (c == 8) btn_ok = 1'b1;
      exp_push($sformatf("rel_press_hold_c%0d", c), (c == 15) ? 32'h0 : 32'h1);
      #1 check_obs(32'(hold));
      if (c == 14) begin
        exp_push("rel_press_in_data_c14", 32'h0000_BEEF);
        check_obs(in_data);
      end
      if (c == 15) begin
        exp_push("rel_press_in_data_c15", 32'h0000_5A5A);
        check_obs(in_data);
      end
    end
    stall = 1'b0;
    btn_ok = 1'b0;
    repeat (8) step();

    // Reset while waiting for the press
    stall = 1'b1; switches = 16'h7777;
    repeat (3) step();
    rst = 1'b1;
    exp_push("midrst_hold", 32'h0);
    exp_push("midrst_in_data", 32'h0);
    exp_push("midrst_out_reg", 32'h0);
    #1;
    check_obs(32'(hold));
    check_obs(in_data);
    check_obs(out_reg);
    step();
    rst = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) step();
      if (c == 1) btn_ok = 1'b1;
      exp_push($sformatf("postrst_hold_c%0d", c), (c == 8) ? 32'h0 : 32'h1);
      #1 check_obs(32'(hold));
      if (c == 8) begin
        exp_push("postrst_in_data", 32'h0000_7777);
        check_obs(in_data);
      end
    end
    stall = 1'b0;
    btn_ok = 1'b0;
    repeat (8) step();

    // Flush: request drops in WAIT_PRESS, later press must not capture
    stall = 1'b1; switches = 16'h1111;
    repeat (2) step();
    stall = 1'b0;
    exp_push("flush_hold_c0", 32'h0);
    #1 check_obs(32'(hold));
    step();
    exp_push("flush_hold_c1", 32'h0);
    exp_push("flush_in_data_c1", 32'h0000_7777);
    #1;
    check_obs(32'(hold));
    check_obs(in_data);
    btn_ok = 1'b1;
    repeat (10) step();
    exp_push("flush_in_data_late", 32'h0000_7777);
    exp_push("flush_out_valid", 32'h0);
    #1;
    check_obs(in_data);
    check_obs(32'(out_valid));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
